// File: rtl/mem_arbiter_if.sv
// Bundles the fetch requester, data requester, memory-side handshake and
// arbiter status into a single bus. The arbiter uses master; the environment uses slave.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [3:0]        d_sel;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic              flush;

   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [3:0]        m_sel;
   logic              m_ack;
   logic [DATA_W-1:0] m_rdata;

   logic              stall_if;
   logic              stall_mem;
   logic              busy;
   logic              err;
   logic              err_src;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_sel, flush, m_ack, m_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, m_sel,
             stall_if, stall_mem, busy, err, err_src
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_sel, flush, m_ack, m_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata, m_sel,
             stall_if, stall_mem, busy, err, err_src
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data access,
// data first, with fetch squashing on flush and timeout abort of hung transactions.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input logic            clk,
   input logic            rst,
   mem_arbiter_if.master  bus
);
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, IBUSY = 2'd1, DBUSY = 2'd2} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_kill;
   logic              r_err_src;
   logic              r_m_req;
   logic              r_m_we;
   logic [ADDR_W-1:0] r_m_addr;
   logic [DATA_W-1:0] r_m_wdata;
   logic [3:0]        r_m_sel;

   logic w_take_d;
   logic w_take_i;
   logic w_done;
   logic w_tmo;
   logic w_end;
   logic w_in_d;
   logic w_in_i;

   always_comb begin
      w_state_next = r_state;
      w_take_d     = 1'b0;
      w_take_i     = 1'b0;
      w_done       = 1'b0;
      w_tmo        = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.d_req) begin
               w_take_d     = 1'b1;
               w_state_next = DBUSY;
            end else if (bus.i_req && !bus.flush) begin
               w_take_i     = 1'b1;
               w_state_next = IBUSY;
            end
         end
         IBUSY, DBUSY: begin
            // A memory ack in the final counted cycle takes precedence over the abort.
            if (bus.m_ack) begin
               w_done       = 1'b1;
               w_state_next = IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_tmo        = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_in_d = (r_state == DBUSY);
   assign w_in_i = (r_state == IBUSY);
   assign w_end  = w_done | w_tmo;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_kill    <= 1'b0;
         r_err_src <= 1'b0;
         r_m_req   <= 1'b0;
         r_m_we    <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
         r_m_sel   <= 4'h0;
      end else begin
         r_state <= w_state_next;
         if (w_take_d) begin
            r_m_req   <= 1'b1;
            r_m_we    <= bus.d_we;
            r_m_addr  <= bus.d_addr;
            r_m_wdata <= bus.d_wdata;
            r_m_sel   <= bus.d_sel;
         end else if (w_take_i) begin
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_addr  <= bus.i_addr;
            r_m_wdata <= '0;
            r_m_sel   <= 4'hF;
         end else if (w_end) begin
            r_m_req <= 1'b0;
         end
         if (w_end || r_state == IDLE) r_cnt <= '0;
         else                          r_cnt <= r_cnt + 1'b1;
         // The squashed fetch still drains at the memory; only its ack is hidden.
         if (w_state_next == IDLE)     r_kill <= 1'b0;
         else if (w_in_i && bus.flush) r_kill <= 1'b1;
         if (w_tmo) r_err_src <= w_in_d;
      end
   end

   assign bus.m_req     = r_m_req;
   assign bus.m_we      = r_m_we;
   assign bus.m_addr    = r_m_addr;
   assign bus.m_wdata   = r_m_wdata;
   assign bus.m_sel     = r_m_sel;

   assign bus.d_ack     = w_in_d & w_end;
   assign bus.i_ack     = w_in_i & w_end & ~r_kill & ~bus.flush;
   assign bus.d_rdata   = (bus.d_ack && w_done) ? bus.m_rdata : '0;
   assign bus.i_rdata   = (bus.i_ack && w_done) ? bus.m_rdata : '0;

   assign bus.err       = w_tmo;
   assign bus.err_src   = w_tmo ? w_in_d : r_err_src;
   assign bus.busy      = (r_state != IDLE);
   assign bus.stall_if  = bus.i_req & ~bus.i_ack & ~bus.flush;
   assign bus.stall_mem = bus.d_req & ~bus.d_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized transactions against a latency-level model of the
// arbiter: data served before fetch, ack after the chosen wait count or abort at TIMEOUT.
module tb_mem_arbiter;
   localparam int TMO = 15;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   logic last_src = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel);
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_sel = sel;
   endtask

   task automatic req_i(input logic [31:0] addr);
      bus.i_req = 1'b1; bus.i_addr = addr;
   endtask

   // Called at a negedge with the request already driven; the next edge grants it.
   task automatic serve(input logic is_d, input logic [31:0] addr, input logic we,
                        input logic [31:0] wdata, input logic [3:0] sel, input int waits,
                        input logic [31:0] rdata, input int flush_at);
      logic        done, abort, killed, ack_exp;
      logic [31:0] rd_exp;
      done   = 1'b0;
      killed = 1'b0;
      for (int k = 0; k < TMO + 2 && !done; k++) begin
         @(posedge clk); #1;
         bus.m_ack   = (k == waits);
         bus.m_rdata = (k == waits) ? rdata : $urandom;
         if (flush_at >= 0 && k == flush_at) begin
            bus.flush = 1'b1; killed = 1'b1;
         end else if (flush_at >= 0 && k == flush_at + 1) begin
            bus.flush = 1'b0; bus.i_req = 1'b0;
         end
         #4;
         abort   = (k == TMO - 1) && (k != waits);
         done    = (k == waits) || abort;
         ack_exp = done && !killed;
         rd_exp  = (ack_exp && !abort) ? rdata : 32'h0;
         $display("t=%0t %s k=%0d addr=%h m_ack=%b d_ack=%b i_ack=%b err=%b", $time,
                  is_d ? "DATA" : "FETCH", k, bus.m_addr, bus.m_ack, bus.d_ack, bus.i_ack, bus.err);
         chk("m_req", bus.m_req, 1);
         chk("busy", bus.busy, 1);
         chk("m_addr", bus.m_addr, addr);
         chk("m_we", bus.m_we, we);
         chk("m_wdata", bus.m_wdata, wdata);
         chk("m_sel", bus.m_sel, sel);
         chk("err", bus.err, abort);
         if (abort) begin
            chk("err_src", bus.err_src, is_d);
            last_src = is_d;
         end
         chk("d_ack", bus.d_ack, is_d & ack_exp);
         chk("i_ack", bus.i_ack, !is_d & ack_exp);
         chk("d_rdata", bus.d_rdata, is_d ? rd_exp : 32'h0);
         chk("i_rdata", bus.i_rdata, is_d ? 32'h0 : rd_exp);
         chk("stall_if", bus.stall_if, bus.i_req & ~(!is_d & ack_exp) & ~bus.flush);
         chk("stall_mem", bus.stall_mem, bus.d_req & ~(is_d & ack_exp));
      end
      @(posedge clk); #1;
      bus.m_ack   = 1'($urandom_range(0, 1));
      bus.m_rdata = $urandom;
      bus.flush   = 1'b0;
      if (is_d) bus.d_req = 1'b0;
      else      bus.i_req = 1'b0;
      #4;
      chk("idle_m_req", bus.m_req, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_err", bus.err, 0);
      chk("idle_d_ack", bus.d_ack, 0);
      chk("idle_i_ack", bus.i_ack, 0);
      chk("idle_d_rdata", bus.d_rdata, 0);
      chk("idle_i_rdata", bus.i_rdata, 0);
      chk("idle_err_src", bus.err_src, last_src);
      bus.m_ack = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_errors %0d", n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] r;
      int          wd, wi, waits, fa;
      logic        we;
      logic [31:0] da, dw, ia;
      logic [3:0]  ds;

      bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
      bus.d_addr = '0; bus.d_wdata = '0; bus.d_sel = 4'h0; bus.flush = 1'b0;
      bus.m_ack = 1'b0; bus.m_rdata = '0;

      // Reset held with both requests pending
      req_d(1'b0, 32'h10, 32'h0, 4'hF);
      req_i(32'h20);
      repeat (2) begin
         @(posedge clk); #5;
         $display("t=%0t RESET m_req=%b busy=%b", $time, bus.m_req, bus.busy);
         chk("rst_m_req", bus.m_req, 0);
         chk("rst_busy", bus.busy, 0);
         chk("rst_m_addr", bus.m_addr, 0);
         chk("rst_m_sel", bus.m_sel, 0);
         chk("rst_d_ack", bus.d_ack, 0);
         chk("rst_i_ack", bus.i_ack, 0);
         chk("rst_err", bus.err, 0);
         chk("rst_err_src", bus.err_src, 0);
      end
      rst = 1'b1;
      serve(1'b1, 32'h10, 1'b0, 32'h0, 4'hF, 0, 32'h11111111, -1);
      serve(1'b0, 32'h20, 1'b0, 32'h0, 4'hF, 0, 32'h22222222, -1);

      // Contention: data wins, fetch follows
      req_i(32'h100);
      req_d(1'b0, 32'h200, 32'h0, 4'hF);
      serve(1'b1, 32'h200, 1'b0, 32'h0, 4'hF, 2, 32'hA5A5A5A5, -1);
      serve(1'b0, 32'h100, 1'b0, 32'h0, 4'hF, 2, 32'h12345678, -1);

      // Partial write
      req_d(1'b1, 32'h40, 32'hDEADBEEF, 4'b0011);
      serve(1'b1, 32'h40, 1'b1, 32'hDEADBEEF, 4'b0011, 1, 32'h0BADF00D, -1);

      // Flush squashes an in-flight fetch
      req_i(32'h300);
      serve(1'b0, 32'h300, 1'b0, 32'h0, 4'hF, 3, 32'hCAFEBABE, 0);

      // Flush in IDLE blocks a new fetch grant
      req_i(32'h500);
      bus.flush = 1'b1;
      @(posedge clk); #5;
      chk("idle_flush_busy", bus.busy, 0);
      chk("idle_flush_stall_if", bus.stall_if, 0);
      bus.flush = 1'b0;
      serve(1'b0, 32'h500, 1'b0, 32'h0, 4'hF, 0, 32'h55555555, -1);

      // Timeouts, and ack landing in the last counted cycle
      req_d(1'b0, 32'h80, 32'h0, 4'hF);
      serve(1'b1, 32'h80, 1'b0, 32'h0, 4'hF, 99, 32'h0, -1);
      req_d(1'b0, 32'h80, 32'h0, 4'hF);
      serve(1'b1, 32'h80, 1'b0, 32'h0, 4'hF, TMO - 1, 32'h77777777, -1);
      req_i(32'h84);
      serve(1'b0, 32'h84, 1'b0, 32'h0, 4'hF, 99, 32'h0, -1);
      req_i(32'h88);
      serve(1'b0, 32'h88, 1'b0, 32'h0, 4'hF, 99, 32'h0, 5);

      // Reset in the middle of a data transaction
      req_d(1'b0, 32'h90, 32'h0, 4'hF);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.d_req = 1'b0;
      @(posedge clk); #4;
      $display("t=%0t MIDRESET m_req=%b busy=%b", $time, bus.m_req, bus.busy);
      chk("midrst_m_req", bus.m_req, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_d_ack", bus.d_ack, 0);
      chk("midrst_err", bus.err, 0);
      #1;
      rst = 1'b1;
      last_src = 1'b0;

      // Back-to-back zero-wait fetches
      for (int a = 0; a < 12; a += 4) begin
         r = $urandom;
         req_i(32'(a));
         serve(1'b0, 32'(a), 1'b0, 32'h0, 4'hF, 0, r, -1);
      end

      // Randomized traffic
      repeat (40) begin
         wd    = int'($urandom_range(0, 1));
         wi    = (wd == 0) ? 1 : int'($urandom_range(0, 1));
         waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 20))
                                            : int'($urandom_range(0, 3));
         we    = 1'($urandom_range(0, 1));
         da    = $urandom; dw = $urandom; ds = 4'($urandom); ia = $urandom;
         fa    = -1;
         if (wd == 0 && $urandom_range(0, 4) == 0)
            fa = int'($urandom_range(0, (waits < TMO - 1) ? waits : TMO - 1));
         if (wd != 0) req_d(we, da, dw, ds);
         if (wi != 0) req_i(ia);
         if (wd != 0) serve(1'b1, da, we, dw, ds, waits, $urandom, -1);
         if (wi != 0) serve(1'b0, ia, 1'b0, 32'h0, 4'hF,
                            (wd != 0) ? int'($urandom_range(0, 3)) : waits, $urandom, fa);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the instruction-fetch requester (PC/IF stage) and the data requester (MEM stage) of the five-stage pipeline. A three-state FSM grants one transaction at a time, with data having priority. It drives the memory-side req/ack handshake from registered payload, and returns per-requester acks and stall requests. It also kills fetches that are squashed by a pipeline flush and aborts hung transactions on timeout.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, cycles a granted transaction may wait for m_ack before abort (≥1)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the clock edge)
- i_req  in  1  fetch request; held with i_addr stable until i_ack or flush
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle fetch completion; i_rdata valid this cycle only
- i_rdata  out  DATA_W  fetched word
- d_req  in  1  data request; held with payload stable until d_ack
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_sel  in  4  byte enables
- d_ack  out  1  one-cycle data completion; d_rdata valid this cycle only
- d_rdata  out  DATA_W  read data
- flush  in  1  pipeline flush; squashes outstanding/pending fetch
- m_req, m_we, m_addr, m_wdata, m_sel  out  1/1/ADDR_W/DATA_W/4  registered memory request
- m_ack  in  1  memory completion; m_rdata valid same cycle
- m_rdata  in  DATA_W  memory read data
- stall_if  out  1  i_req & ~i_ack & ~flush
- stall_mem  out  1  d_req & ~d_ack
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse on timeout abort
- err_src  out  1  0=fetch, 1=data; valid with err, holds last value otherwise

## Operation
- States: IDLE, IBUSY, DBUSY. Reset → IDLE, counter 0, kill flag 0, all registered outputs 0.
- IDLE: d_req=1 → latch d_we/d_addr/d_wdata/d_sel into m_*, m_req<=1, → DBUSY. Else if i_req=1 and flush=0 → latch i_addr, m_we<=0, m_sel<=4'hF, m_wdata<=0, m_req<=1, → IBUSY. Else stay.
- Data beats fetch on simultaneous requests (older instruction first); no fairness counter.
- BUSY with m_ack=1: m_req<=0, counter<=0, → IDLE. Requester ack combinational in that cycle: d_ack=m_ack in DBUSY; i_ack=m_ack&~kill&~flush in IBUSY. Read data passed straight from m_rdata.
- BUSY with m_ack=0: counter+1; if counter==TIMEOUT-1 → m_req<=0, → IDLE, err=1 same cycle, err_src set, requester ack pulses this cycle with rdata=0 (IBUSY: unless killed).
- m_ack and timeout in same cycle: m_ack wins, no err.
- flush in IBUSY: kill<=1; memory transaction runs to m_ack/timeout, i_ack suppressed; kill cleared on return to IDLE. flush has no effect on DBUSY.
- m_ack in IDLE ignored. d_rdata/i_rdata are 0 when not acked.
- Reset asserted mid-transaction: next edge m_req=0, IDLE, no ack, no err.

## Timing
- Request sampled in cycle 0 (IDLE) → m_req high from cycle 1.
- Zero-wait memory (m_ack in cycle 1) → ack in cycle 1, IDLE in cycle 2; new request may be accepted in cycle 2. Back-to-back throughput: one transaction per 2 cycles.
- Requester must drop or change req in the cycle after its ack; a req seen in IDLE is always a new request.
- m_* payload stable for whole m_req assertion.
- stall_if/stall_mem purely combinational, zero latency.

## Test plan
- Reset: rst=0 two cycles with i_req=d_req=1 → all outputs 0, busy=0; release → m_req=1 with data payload one cycle later.
- Contention: i_req (addr 0x100) and d_req read (addr 0x200) both in cycle 0, memory acks after 2 waits returning 0xA5A5A5A5 then 0x12345678 → d_ack first with 0xA5A5A5A5, then m_addr=0x100, i_ack with 0x12345678; stall_if high throughout until i_ack.
- Write: d_we=1, addr 0x40, wdata 0xDEADBEEF, sel 4'b0011 → m_we=1 and payload exact while m_req high; d_ack on m_ack.
- Flush: fetch 0x300 granted, flush pulse in IBUSY, m_ack 3 cycles later → no i_ack, stall_if=0 during flush, busy drops after m_ack.
- Timeout: DBUSY with m_ack never asserted, TIMEOUT=15 → err=1, err_src=1, d_ack=1, d_rdata=0 in the 15th BUSY cycle; m_req low next cycle. Repeat with m_ack in that same cycle → no err.
- Back-to-back zero-wait fetches 0x0,0x4,0x8 → i_ack every 2 cycles, addresses in order.
